ps2_key_decoder: RTL and testbench

//  Consumes the byte stream from the PS/2 receiver (key_code + 1-cycle data_ready)
//  and decodes scan-code set 2 prefixes (E0 extended, F0 break, E1 pause).

---
 rtl/ps2_key_decoder.sv | 184 ++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 decoder: prefix FSM, show-ahead event FIFO, held game-key levels.
// Optional build macro PS2_REPEAT_FILTER_EN suppresses typematic repeats of the last make.
module ps2_key_decoder #(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] key_code,
   input  logic       data_ready,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [9:0] ev_data,
   output logic       overflow,
   output logic       key_up,
   output logic       key_down,
   output logic       key_left,
   output logic       key_right,
   output logic       key_enter,
   output logic       key_esc
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

   state_t        state, state_n;
   logic [2:0]    skip, skip_n;
   logic [TW-1:0] to_cnt, to_n;
   logic          evt, evt_brk, evt_ext, suppress, apply;

   logic [9:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [9:0]    hold_q;
   logic          full, pop, push_ok;

   always_comb begin
      state_n = state;
      skip_n  = skip;
      to_n    = to_cnt;
      evt     = 1'b0;
      evt_brk = 1'b0;
      evt_ext = 1'b0;
      if (data_ready) begin
         to_n = '0;
         case (state)
            IDLE: begin
               if (key_code == 8'hE0)      state_n = EXT;
               else if (key_code == 8'hF0) state_n = BRK;
               else if (key_code == 8'hE1) begin
                  state_n = SKIP;
                  skip_n  = 3'd7;
               end else if (!(key_code inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hEE}))
                  evt = 1'b1;
            end
            EXT: begin
               if (key_code == 8'hF0) state_n = EXT_BRK;
               else begin
                  state_n = IDLE;
                  evt_ext = 1'b1;
                  evt     = !(key_code inside {8'hE0, 8'hE1, 8'h12, 8'h59});
               end
            end
            BRK: begin
               state_n = IDLE;
               evt     = 1'b1;
               evt_brk = 1'b1;
            end
            EXT_BRK: begin
               state_n = IDLE;
               evt_brk = 1'b1;
               evt_ext = 1'b1;
               evt     = !(key_code inside {8'h12, 8'h59});
            end
            SKIP: begin
               skip_n = skip - 3'd1;
               if (skip <= 3'd1) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end else if (state != IDLE) begin
         if (to_cnt == TO_LAST) begin
            state_n = IDLE;
            to_n    = '0;
            skip_n  = '0;
         end else begin
            to_n = to_cnt + 1'b1;
         end
      end else begin
         to_n = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         skip   <= '0;
         to_cnt <= '0;
      end else begin
         state  <= state_n;
         skip   <= skip_n;
         to_cnt <= to_n;
      end
   end

`ifdef PS2_REPEAT_FILTER_EN
   logic [8:0] last_make;
   logic       last_valid;

   assign suppress = evt && !evt_brk && last_valid && (last_make == {evt_ext, key_code});

   always_ff @(posedge clk) begin
      if (rst) begin
         last_make  <= '0;
         last_valid <= 1'b0;
      end else if (evt && !evt_brk) begin
         last_make  <= {evt_ext, key_code};
         last_valid <= 1'b1;
      end else if (evt && evt_brk && (last_make == {evt_ext, key_code})) begin
         last_valid <= 1'b0;
      end
   end
`else
   assign suppress = 1'b0;
`endif

   assign apply = evt && !suppress;

   always_ff @(posedge clk) begin
      if (rst) begin
         key_up    <= 1'b0;
         key_down  <= 1'b0;
         key_left  <= 1'b0;
         key_right <= 1'b0;
         key_enter <= 1'b0;
         key_esc   <= 1'b0;
      end else if (apply) begin
         case ({evt_ext, key_code})
            9'h175:  key_up    <= !evt_brk;
            9'h172:  key_down  <= !evt_brk;
            9'h16B:  key_left  <= !evt_brk;
            9'h174:  key_right <= !evt_brk;
            9'h05A:  key_enter <= !evt_brk;
            9'h076:  key_esc   <= !evt_brk;
            default: ;
         endcase
      end
   end

   assign full     = (count == FULL_CNT);
   assign ev_valid = (count != '0);
   assign pop      = ev_valid && ev_ready;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign push_ok  = apply && (!full || pop);
   assign ev_data  = ev_valid ? mem[rd_ptr] : hold_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         hold_q   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= {evt_brk, evt_ext, key_code};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            hold_q <= mem[rd_ptr];
         end
         if (apply && !push_ok) overflow <= 1'b1;
         if (push_ok && !pop)      count <= count + 1'b1;
         else if (!push_ok && pop) count <= count - 1'b1;
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed byte streams, expected events queued,
// monitor compares each popped event. Honours PS2_REPEAT_FILTER_EN like the design.
module tb_ps2_key_decoder;

   localparam int unsigned T = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] key_code;
   logic       data_ready;
   logic       ev_valid;
   logic       ev_ready;
   logic [9:0] ev_data;
   logic       overflow;
   logic       key_up, key_down, key_left, key_right, key_enter, key_esc;

   int checks   = 0;
   int failures = 0;
   logic [9:0] sb[$];

   ps2_key_decoder #(.DEPTH(4), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .key_code(key_code), .data_ready(data_ready),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data), .overflow(overflow),
      .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
      .key_enter(key_enter), .key_esc(key_esc)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && ev_valid && ev_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got=%0h expected=none", ev_data);
         end else begin
            check("event", {22'd0, ev_data}, {22'd0, sb.pop_front()});
         end
      end
   end

   task automatic send(input logic [7:0] b);
      @(posedge clk);
      #1 key_code = b;
      data_ready = 1'b1;
      @(posedge clk);
      #1 data_ready = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   task automatic drain(input string name);
      ev_ready = 1'b1;
      idle(8);
      check({name, "_empty"}, {31'd0, ev_valid}, 32'd0);
      check({name, "_sb_left"}, sb.size(), 32'd0);
   endtask

   initial begin
      rst = 1'b1; key_code = '0; data_ready = 1'b0; ev_ready = 1'b1;
      idle(3);
      rst = 1'b0;
      check("rst_valid", {31'd0, ev_valid}, 32'd0);
      check("rst_data", {22'd0, ev_data}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      check("rst_keys", {26'd0, key_up, key_down, key_left, key_right, key_enter, key_esc}, 32'd0);

      // 1: single make, one-cycle latency, pop, head held when empty
      sb.push_back(10'h01C);
      send(8'h1C);
      check("t1_valid", {31'd0, ev_valid}, 32'd1);
      check("t1_data", {22'd0, ev_data}, 32'h01C);
      idle(1);
      check("t1_popped", {31'd0, ev_valid}, 32'd0);
      check("t1_hold", {22'd0, ev_data}, 32'h01C);

      // 2: extended make/break with key_up level
      sb.push_back(10'h175);
      send(8'hE0); send(8'h75);
      check("t2_up_set", {31'd0, key_up}, 32'd1);
      sb.push_back(10'h375);
      send(8'hE0); send(8'hF0); send(8'h75);
      check("t2_up_clr", {31'd0, key_up}, 32'd0);

      // 3: enter make/break, ignored bytes, fake shift, pause sequence
      sb.push_back(10'h05A);
      send(8'h5A);
      check("t3_enter_set", {31'd0, key_enter}, 32'd1);
      sb.push_back(10'h25A);
      send(8'hF0); send(8'h5A);
      check("t3_enter_clr", {31'd0, key_enter}, 32'd0);
      send(8'hAA); send(8'hFA); send(8'h00);
      send(8'hE0); send(8'h12);
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      sb.push_back(10'h029);
      send(8'h29);
      drain("t3");

      // 4: fill, overflow, ordered pops, push+pop while full
      ev_ready = 1'b0;
      sb.push_back(10'h015); sb.push_back(10'h01D);
      sb.push_back(10'h024); sb.push_back(10'h02D);
      send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
      check("t4_no_ovf_yet", {31'd0, overflow}, 32'd0);
      send(8'h2C);
      check("t4_ovf", {31'd0, overflow}, 32'd1);
      check("t4_head", {22'd0, ev_data}, 32'h015);
      sb.push_back(10'h02E);
      @(posedge clk);
      #1 ev_ready = 1'b1; key_code = 8'h2E; data_ready = 1'b1;
      @(posedge clk);
      #1 data_ready = 1'b0; ev_ready = 1'b0;
      check("t4_head2", {22'd0, ev_data}, 32'h01D);
      send(8'h36);
      drain("t4");
      check("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

      // 5: timeout boundary, and reset discarding a pending prefix
      sb.push_back(10'h16B);
      send(8'hE0); idle(T - 4); send(8'h6B);
      check("t5_left_set", {31'd0, key_left}, 32'd1);
      sb.push_back(10'h36B);
      send(8'hE0); send(8'hF0); send(8'h6B);
      check("t5_left_clr", {31'd0, key_left}, 32'd0);
      sb.push_back(10'h06B);
      send(8'hE0); idle(T); send(8'h6B);
      check("t5_left_timeout", {31'd0, key_left}, 32'd0);
      drain("t5a");
      send(8'hF0);
      do_reset();
      check("t5_rst_ovf", {31'd0, overflow}, 32'd0);
      sb.push_back(10'h01C);
      send(8'h1C);
      drain("t5b");

      // 6: typematic repeats
      do_reset();
`ifdef PS2_REPEAT_FILTER_EN
      sb.push_back(10'h01C); sb.push_back(10'h21C); sb.push_back(10'h01C);
`else
      sb.push_back(10'h01C); sb.push_back(10'h01C); sb.push_back(10'h01C);
      sb.push_back(10'h21C); sb.push_back(10'h01C);
`endif
      send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
      drain("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
